// File: rtl/stopwatch_timer_core.sv
// stopwatch_timer_core: BCD stopwatch/timer with prescaler, up/down count, preset load and done pulse.
// Optional lap/split display freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_timer_core #(
    parameter int TICK_DIV = 5000000,
    parameter int MIN_W    = 4,
    parameter int MIN_MAX  = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             load,
    input  logic             mode,
    input  logic             lap,
    input  logic [3:0]       preset_t,
    input  logic [3:0]       preset_s,
    input  logic [2:0]       preset_ten,
    input  logic [MIN_W-1:0] preset_min,
    output logic [3:0]       sec_t,
    output logic [3:0]       sec_s,
    output logic [2:0]       ten,
    output logic [MIN_W-1:0] min,
    output logic             running,
    output logic             done,
    output logic             lap_active
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [MIN_W-1:0] MMAX = MIN_W'(MIN_MAX);

    logic [PW-1:0]    presc;
    logic             run_q, mode_q, done_q;
    logic [3:0]       t, s, nt, ns;
    logic [2:0]       tn, ntn;
    logic [MIN_W-1:0] m, nm;
    logic             tick, at_zero, term, c_t, c_s, c_tn;

    // One cascade serves both directions: carry on 9/5 counting up, borrow on 0 counting down.
    always_comb begin
        tick    = presc == PW'(TICK_DIV - 1);
        at_zero = {m, tn, s, t} == '0;
        c_t     = mode_q ? t == 4'd0 : t == 4'd9;
        c_s     = c_t && (mode_q ? s == 4'd0 : s == 4'd9);
        c_tn    = c_s && (mode_q ? tn == 3'd0 : tn == 3'd5);
        nt      = c_t ? (mode_q ? 4'd9 : 4'd0) : (mode_q ? t - 4'd1 : t + 4'd1);
        ns      = !c_t ? s : c_s ? (mode_q ? 4'd9 : 4'd0) : (mode_q ? s - 4'd1 : s + 4'd1);
        ntn     = !c_s ? tn : c_tn ? (mode_q ? 3'd5 : 3'd0) : (mode_q ? tn - 3'd1 : tn + 3'd1);
        nm      = !c_tn ? m : mode_q ? m - MIN_W'(1) : m + MIN_W'(1);
        term    = mode_q ? {nm, ntn, ns, nt} == '0
                         : (m == MMAX && tn == 3'd5 && s == 4'd9 && t == 4'd9);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {t, s, tn, m} <= '0;
            presc         <= '0;
            run_q         <= 1'b0;
            mode_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!run_q) begin
                if (clear) begin
                    {t, s, tn, m} <= '0;
                    presc         <= '0;
                end else if (load) begin
                    t     <= preset_t > 4'd9 ? 4'd9 : preset_t;
                    s     <= preset_s > 4'd9 ? 4'd9 : preset_s;
                    tn    <= preset_ten > 3'd5 ? 3'd5 : preset_ten;
                    m     <= preset_min > MMAX ? MMAX : preset_min;
                    presc <= '0;
                end else if (start_stop && !(mode && at_zero)) begin
                    run_q  <= 1'b1;
                    mode_q <= mode;
                    presc  <= '0;
                end
            end else if (tick && term) begin
                // Counting up saturates at the maximum; counting down lands on zero.
                if (mode_q) {t, s, tn, m} <= {nt, ns, ntn, nm};
                run_q  <= 1'b0;
                done_q <= 1'b1;
                presc  <= '0;
            end else if (start_stop) begin
                run_q <= 1'b0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) {t, s, tn, m} <= {nt, ns, ntn, nm};
            end
        end
    end

    assign running = run_q;
    assign done    = done_q;

`ifdef STOPWATCH_LAP_EN
    logic             lap_q;
    logic [3:0]       lt, ls;
    logic [2:0]       ltn;
    logic [MIN_W-1:0] lm;

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_q <= 1'b0;
        end else if (run_q && lap) begin
            lap_q              <= 1'b1;
            {lt, ls, ltn, lm}  <= {t, s, tn, m};
        end else if (!run_q && (lap || clear || load)) begin
            lap_q <= 1'b0;
        end
    end

    assign lap_active = lap_q;
    assign sec_t      = lap_q ? lt : t;
    assign sec_s      = lap_q ? ls : s;
    assign ten        = lap_q ? ltn : tn;
    assign min        = lap_q ? lm : m;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_active = 1'b0;
    assign sec_t      = t;
    assign sec_s      = s;
    assign ten        = tn;
    assign min        = m;
`endif
endmodule

// File: tb/tb_stopwatch_timer_core.sv
// tb_stopwatch_timer_core: directed and random stimulus against a total-tenths reference model.
module tb_stopwatch_timer_core;
    localparam int TD  = 4;
    localparam int MW  = 4;
    localparam int MM  = 9;
    localparam int MAX = MM * 600 + 599;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start_stop, clear, load, mode, lap;
    logic [3:0]    preset_t, preset_s, sec_t, sec_s;
    logic [2:0]    preset_ten, ten;
    logic [MW-1:0] preset_min, min;
    logic          running, done, lap_active;

    stopwatch_timer_core #(.TICK_DIV(TD), .MIN_W(MW), .MIN_MAX(MM)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .load(load),
        .mode(mode), .lap(lap), .preset_t(preset_t), .preset_s(preset_s),
        .preset_ten(preset_ten), .preset_min(preset_min), .sec_t(sec_t), .sec_s(sec_s),
        .ten(ten), .min(min), .running(running), .done(done), .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int val = 0, frozen = 0, pc = 0;
    bit run = 0, dir = 0, dn = 0, la = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lim(input int v, input int mx);
        return v > mx ? mx : v;
    endfunction

    function automatic int shown();
        return int'(sec_t) + 10 * int'(sec_s) + 100 * int'(ten) + 600 * int'(min);
    endfunction

    // Model keeps the time as a single count of tenths; digits are derived only for comparison.
    task automatic step(input bit r, input bit ss, input bit clr, input bit ld, input bit lp);
        bit tick;
        int dv;
        reset = r; start_stop = ss; clear = clr; load = ld; lap = lp;
        @(posedge clk);
        if (r) begin
            val = 0; run = 0; dir = 0; pc = 0; dn = 0; la = 0;
        end else begin
            dn = 0;
            if (!run) begin
                if (clr) begin
                    val = 0; pc = 0; la = 0;
                end else if (ld) begin
                    val = lim(preset_t, 9) + 10 * lim(preset_s, 9) + 100 * lim(preset_ten, 5)
                        + 600 * lim(preset_min, MM);
                    pc = 0; la = 0;
                end else if (ss && !(mode && val == 0)) begin
                    run = 1; dir = mode; pc = 0;
                end
                if (LAP && lp) la = 0;
            end else begin
                tick = pc == TD - 1;
                if (LAP && lp) begin
                    frozen = val; la = 1;
                end
                if (tick && (dir ? val == 1 : val == MAX)) begin
                    if (dir) val = 0;
                    run = 0; dn = 1; pc = 0;
                end else if (ss) begin
                    run = 0;
                end else begin
                    if (tick) val = dir ? val - 1 : val + 1;
                    pc = tick ? 0 : pc + 1;
                end
            end
        end
        @(negedge clk);
        reset = 0; start_stop = 0; clear = 0; load = 0; lap = 0;
        dv = la ? frozen : val;
        chk("sec_t", sec_t, dv % 10);
        chk("sec_s", sec_s, (dv / 10) % 10);
        chk("ten", ten, (dv / 100) % 6);
        chk("min", min, dv / 600);
        chk("running", running, run);
        chk("done", done, dn);
        chk("lap_active", lap_active, la);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic set_preset(input int pt, input int ps, input int pten, input int pm);
        preset_t = 4'(pt); preset_s = 4'(ps); preset_ten = 3'(pten); preset_min = MW'(pm);
    endtask

    initial begin
        reset = 1; start_stop = 0; clear = 0; load = 0; mode = 0; lap = 0;
        set_preset(0, 0, 0, 0);
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_val", shown(), 0);
        chk("rst_run", running, 0);

        step(0, 1, 0, 0, 0);
        idle(3);
        chk("pre_tick", shown(), 0);
        idle(1);
        chk("first_tick", shown(), 1);
        idle(36);
        chk("ten_ticks", shown(), 10);
        chk("ten_ticks_run", running, 1);
        step(0, 1, 0, 0, 0);

        set_preset(8, 9, 5, 9);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        idle(4);
        chk("up_max", shown(), 5999);
        idle(4);
        chk("sat_val", shown(), 5999);
        chk("sat_done", done, 1);
        chk("sat_run", running, 0);
        idle(1);
        chk("sat_done_end", done, 0);

        mode = 1;
        set_preset(0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        idle(4);
        chk("down_borrow", shown(), 599);
        step(0, 1, 0, 0, 0);
        set_preset(2, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        idle(8);
        chk("down_zero", shown(), 0);
        chk("down_done", done, 1);
        chk("down_run", running, 0);
        step(0, 1, 0, 0, 0);
        chk("zero_start_ign", running, 0);

        mode = 0;
        set_preset(3, 12, 7, 15);
        step(0, 0, 0, 1, 0);
        chk("clamp", shown(), 5993);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        set_preset(0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("run_ign_cmd", shown(), 5993);
        step(0, 1, 0, 0, 0);

        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(34 * TD);
        chk("mid_val", shown(), 34);
        step(1, 1, 0, 0, 0);
        chk("mid_rst_val", shown(), 0);
        chk("mid_rst_run", running, 0);
        chk("mid_rst_done", done, 0);

        step(0, 1, 0, 0, 0);
        idle(23 * TD);
        step(0, 0, 0, 0, 1);
`ifdef STOPWATCH_LAP_EN
        chk("lap_hold", shown(), 23);
        chk("lap_act", lap_active, 1);
`endif
        idle(59);
        step(0, 0, 0, 0, 1);
`ifdef STOPWATCH_LAP_EN
        chk("split", shown(), 38);
`endif
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("lap_release", shown(), 38);
        chk("lap_release_act", lap_active, 0);

        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) mode = 1'($urandom);
            if ($urandom_range(0, 9) == 0)
                set_preset($urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 7), $urandom_range(0, 15));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 24) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_timer_core.md
Name: stopwatch_timer_core

Overview:
- Parametrised next-generation time-keeping block for the lab stopwatch: tenths, seconds, tens-of-seconds and minutes digits in BCD.
- Adds an internal tick prescaler, count-up/count-down modes, preset load, terminal-count detection and start/stop/clear control.
- Digit outputs drive the existing 7-segment display path; done drives a buzzer/LED.

Parameters:
- TICK_DIV, 5000000, clk cycles per tenth-second tick (>=2); 5000000 gives 10 Hz at 50 MHz.
- MIN_W, 4, width of minutes field.
- MIN_MAX, 9, largest minutes value (must be < 2**MIN_W).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start_stop  in  1  one-cycle pulse; toggles run state
- clear  in  1  one-cycle pulse; zeroes digits (honoured only while stopped)
- load  in  1  one-cycle pulse; loads preset digits (honoured only while stopped)
- mode  in  1  0 = count up, 1 = count down; sampled only while stopped
- lap  in  1  one-cycle pulse; lap/split control (see Optional Feature)
- preset_t  in  4  preset tenths
- preset_s  in  4  preset seconds units
- preset_ten  in  3  preset tens of seconds
- preset_min  in  MIN_W  preset minutes
- sec_t  out  4  tenths digit, 0-9
- sec_s  out  4  seconds units, 0-9
- ten  out  3  tens of seconds, 0-5
- min  out  MIN_W  minutes, 0-MIN_MAX
- running  out  1  1 while counting
- done  out  1  one-cycle pulse at terminal count
- lap_active  out  1  1 while displayed value is frozen

Behaviour:
- Reset: all digits 0, running=0, done=0, lap_active=0, prescaler=0, latched mode=0.
- Command priority within one cycle: reset > clear > load > start_stop > tick.
- States:
  - STOPPED
    - start_stop -> RUNNING, latches mode, prescaler=0.
    - Exception: mode=1 and value is 0:00.0 -> start_stop ignored, stay STOPPED.
  - RUNNING
    - start_stop -> STOPPED; digits hold; prescaler holds its value.
    - clear, load and mode changes ignored.
- Prescaler: counts only in RUNNING.
  - tick is internal, asserted when prescaler == TICK_DIV-1; prescaler then wraps to 0.
  - First tick occurs TICK_DIV cycles after the start edge.
  - Digits update on the tick edge and are visible the following cycle.
- Count up (cascaded BCD):
  - sec_t 9->0 carries into sec_s; sec_s 9->0 carries into ten; ten 5->0 carries into min.
  - At MIN_MAX:59.9 the next tick holds the value (saturates), clears running and pulses done.
- Count down (cascaded BCD):
  - sec_t 0->9 borrows from sec_s; sec_s 0->9 borrows from ten; ten 0->5 borrows from min.
  - The tick that produces 0:00.0 clears running and pulses done.
- done: high exactly one cycle, the cycle after the terminal tick edge.
- clear: sets digits to 0, prescaler to 0.
- load: copies preset digits, each clamped independently (digit>9 -> 9, ten>5 -> 5, min>MIN_MAX -> MIN_MAX); prescaler to 0.
- Reset mid-count: next cycle identical to power-on reset state; no done pulse.
- start_stop in the same cycle as a terminal tick: terminal handling wins, block ends STOPPED, done pulses.

Optional Feature:
- Macro STOPWATCH_LAP_EN.
- Defined:
  - lap while RUNNING copies live digits to a display register and sets lap_active=1; outputs show the frozen copy while live counting continues.
  - lap while already frozen and running refreshes the copy (split).
  - lap while STOPPED, clear, load or reset sets lap_active=0 and outputs return to live digits.
  - Terminal count does not release the freeze.
- Not defined: lap ignored, lap_active tied 0, outputs always live digits.

Test Plan:
- TICK_DIV=4; reset; start_stop at cycle 0 -> first change sec_t 0->1 visible at cycle 5; after 10 ticks reads 0:01.0, running=1.
- Up mode, load preset 9:59.8 (MIN_MAX=9), start -> 9:59.9 after one tick, next tick holds 9:59.9, running=0, done=1 for exactly one cycle.
- Down mode, load 1:00.0, start -> after one tick reads 0:59.9; load 0:00.2, start -> two ticks later 0:00.0, done pulse, running=0; start_stop again is ignored.
- Load preset_s=12, preset_ten=7, preset_min=15 -> reads 9:59.x with sec_s=9, ten=5, min=9; clear and load pulsed while RUNNING -> no change.
- Reset asserted mid-count at 0:03.4 with start_stop in the same cycle -> next cycle 0:00.0, running=0, done=0.
- With STOPWATCH_LAP_EN: lap at 0:02.3 -> outputs hold 0:02.3, lap_active=1; 15 ticks later lap -> shows 0:03.8; stop then lap -> live value shown, lap_active=0.
